// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request/ack handshake and instruction register.
// Optional IF_STAGE_TIMEOUT_EN adds an ack-timeout counter that drops the stage into ERR.
module if_stage #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            fetch_req,
   input  logic            pc_update,
   input  logic            pc_src,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic [6:0]      opcode,
   output logic            instr_valid,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_err
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   if (TIMEOUT < 1 || TIMEOUT > 255 || RESET_PC[1:0] != 2'b00) begin : g_param_check
      $error("if_stage: TIMEOUT must be 1..255 and RESET_PC word aligned");
   end

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_ERR} state_t;

   state_t            state;
   logic              pend_valid;
   logic              pend_src;
   logic [XLEN-1:0]   pend_target;
`ifdef IF_STAGE_TIMEOUT_EN
   logic [7:0]        cnt;
`endif

   logic              upd_c;
   logic              upd_src_c;
   logic              upd_bad_c;
   logic [XLEN-1:0]   upd_target_c;
   logic [XLEN-1:0]   pc_next_c;

   assign pc_plus4  = pc + XLEN'(4);
   assign imem_addr = pc;
   assign opcode    = instr[6:0];

   // A live pc_update pulse supersedes one deferred from the REQ phase.
   always_comb begin
      upd_c        = pc_update | pend_valid;
      upd_src_c    = pc_update ? pc_src : pend_src;
      upd_target_c = pc_update ? branch_target : pend_target;
      upd_bad_c    = upd_c && upd_src_c && (upd_target_c[1:0] != 2'b00);
      pc_next_c    = upd_src_c ? upd_target_c : pc_plus4;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         instr       <= NOP;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
         fetch_err   <= 1'b0;
         pend_valid  <= 1'b0;
         pend_src    <= 1'b0;
         pend_target <= '0;
`ifdef IF_STAGE_TIMEOUT_EN
         cnt         <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               pend_valid <= 1'b0;
               if (upd_bad_c) begin
                  state       <= S_ERR;
                  fetch_err   <= 1'b1;
                  instr       <= NOP;
                  instr_valid <= 1'b0;
               end else begin
                  if (upd_c) begin
                     pc          <= pc_next_c;
                     instr_valid <= 1'b0;
                  end
                  // imem_addr follows pc, so a same-edge update is seen by this fetch
                  if (fetch_req) begin
                     state       <= S_REQ;
                     imem_req    <= 1'b1;
                     instr_valid <= 1'b0;
`ifdef IF_STAGE_TIMEOUT_EN
                     cnt         <= '0;
`endif
                  end
               end
            end
            S_REQ: begin
               if (pc_update) begin
                  pend_valid  <= 1'b1;
                  pend_src    <= pc_src;
                  pend_target <= branch_target;
               end
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  imem_req    <= 1'b0;
                  state       <= S_DONE;
               end else begin
`ifdef IF_STAGE_TIMEOUT_EN
                  if (cnt + 8'd1 == 8'(TIMEOUT)) begin
                     state     <= S_ERR;
                     imem_req  <= 1'b0;
                     fetch_err <= 1'b1;
                     instr     <= NOP;
                  end
                  cnt <= cnt + 8'd1;
`endif
               end
            end
            S_ERR: begin
               pend_valid <= 1'b0;
            end
            default: begin
               state <= S_ERR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: vector table for single-edge behaviour plus hand sequences
// for wait states, deferred PC update, misaligned branch, timeout and async reset.
module tb_if_stage;

   localparam int unsigned XLEN = 32;
   localparam logic [31:0] NOP  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_req, pc_update, pc_src, imem_ack;
   logic [31:0] branch_target, imem_rdata;
   logic        imem_req, instr_valid, fetch_err;
   logic [31:0] imem_addr, instr, pc, pc_plus4;
   logic [6:0]  opcode;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        fr, pu, ps;
      logic [31:0] bt;
      logic        ack;
      logic [31:0] rd;
      logic [31:0] e_pc, e_instr;
      logic        e_valid, e_req, e_err;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   if_stage #(.XLEN(XLEN), .RESET_PC(32'h0), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_update(pc_update),
      .pc_src(pc_src), .branch_target(branch_target), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid), .pc(pc),
      .pc_plus4(pc_plus4), .fetch_err(fetch_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic fr, input logic pu, input logic ps,
                        input logic [31:0] bt, input logic ack, input logic [31:0] rd);
      fetch_req = fr; pc_update = pu; pc_src = ps;
      branch_target = bt; imem_ack = ack; imem_rdata = rd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                              input logic e_valid, input logic e_req, input logic e_err);
      logic [31:0] e_p4;
      e_p4 = e_pc + 32'd4;
      check({tag, " pc"}, pc, e_pc);
      check({tag, " pc_plus4"}, pc_plus4, e_p4);
      if (e_req) check({tag, " imem_addr"}, imem_addr, e_pc);
      check({tag, " instr"}, instr, e_instr);
      check({tag, " opcode"}, 32'(opcode), 32'(e_instr[6:0]));
      check({tag, " instr_valid"}, 32'(instr_valid), 32'(e_valid));
      check({tag, " imem_req"}, 32'(imem_req), 32'(e_req));
      check({tag, " fetch_err"}, 32'(fetch_err), 32'(e_err));
   endtask

   function automatic vec_t mk(input logic fr, input logic pu, input logic ps, input logic [31:0] bt,
                               input logic ack, input logic [31:0] rd, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic e_valid, input logic e_req,
                               input logic e_err);
      vec_t v;
      v.fr = fr; v.pu = pu; v.ps = ps; v.bt = bt; v.ack = ack; v.rd = rd;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_valid = e_valid; v.e_req = e_req; v.e_err = e_err;
      return v;
   endfunction

   initial begin
      //              fr pu ps bt            ack rd            pc            instr         v  rq er
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        NOP,          0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00500093, 32'h0,        32'h00500093, 1, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h4,        32'h00500093, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h8,        32'h00500093, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'hC,        32'h00500093, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h10,       32'h00500093, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,        32'h40,       32'h00500093, 0, 0, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h40,       32'h00500093, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00100073, 32'h40,       32'h00100073, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        32'h40,       32'h00100073, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,        32'hFFFFFFFC, 32'h00100073, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        32'h0,        32'h00100073, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 32'h8,        0, 32'h0,        32'h8,        32'h00100073, 0, 1, 0));
      vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        32'h8,        32'h00100073, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAAAAAA33, 32'h8,        32'hAAAAAA33, 1, 0, 0));

      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
      check("reset imem_addr", imem_addr, 32'h0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].fr, vecs[i].pu, vecs[i].ps, vecs[i].bt, vecs[i].ack, vecs[i].rd);
         tick();
         check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                     vecs[i].e_valid, vecs[i].e_req, vecs[i].e_err);
      end

      // Three wait cycles at pc=0x8 with a sequential pc_update arriving mid-request
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("wait req", 32'h8, 32'hAAAAAA33, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("wait w1", 32'h8, 32'hAAAAAA33, 1'b0, 1'b1, 1'b0);
      idle();
      tick();
      check_state("wait w2", 32'h8, 32'hAAAAAA33, 1'b0, 1'b1, 1'b0);
      tick();
      check_state("wait w3", 32'h8, 32'hAAAAAA33, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00C00113);
      tick();
      check_state("wait ack", 32'h8, 32'h00C00113, 1'b1, 1'b0, 1'b0);
      idle();
      tick();
      check_state("pending applied", 32'hC, 32'h00C00113, 1'b0, 1'b0, 1'b0);

      // Aligned then misaligned branch target
      drive(1'b0, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      check_state("branch 40", 32'h40, 32'h00C00113, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
      tick();
      check_state("misaligned", 32'h40, NOP, 1'b0, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h12345678);
      tick();
      check_state("err sticky", 32'h40, NOP, 1'b0, 1'b0, 1'b1);
      idle();

      // Ack withheld
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_state("err reset", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      idle();
`ifdef IF_STAGE_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         tick();
         check($sformatf("timeout req c%0d", k), 32'(imem_req), (k < 15) ? 32'd1 : 32'd0);
         check($sformatf("timeout err c%0d", k), 32'(fetch_err), (k < 15) ? 32'd0 : 32'd1);
      end
      check_state("timeout err", 32'h0, NOP, 1'b0, 1'b0, 1'b1);
`else
      for (int k = 1; k <= 100; k++) begin
         tick();
         check($sformatf("hold req c%0d", k), 32'(imem_req), 32'd1);
      end
      check_state("hold", 32'h0, NOP, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00208133);
      tick();
      check_state("late ack", 32'h0, 32'h00208133, 1'b1, 1'b0, 1'b0);
      idle();
`endif

      // Asynchronous reset in the middle of a request
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
      tick();
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("pre-reset req", 32'h20, NOP, 1'b0, 1'b1, 1'b0);
      idle();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_state("async reset", 32'h0, NOP, 1'b0, 1'b0, 1'b0);
      check("async reset imem_addr", imem_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_state("refetch req", 32'h0, NOP, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00500093);
      tick();
      check_state("refetch ack", 32'h0, 32'h00500093, 1'b1, 1'b0, 1'b0);
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
